// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result bundle for the pipelined adder/subtractor
interface pipelined_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  modport master (
    output in_valid, sub, a, b, stall,
    input  out_valid, result, negative, zero, carry_out, overflow
  );
  modport slave (
    input  in_valid, sub, a, b, stall,
    output out_valid, result, negative, zero, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: CHUNK-sliced pipelined adder/subtractor producing NZCV flags
module pipelined_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic               clk,
  input logic               reset,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  if (WIDTH % CHUNK != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end
  typedef struct packed {
    logic             v;
    logic             s;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } slot_t;
  slot_t            st [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic             nc [STAGES];
  logic [WIDTH-1:0] bx;
  logic [CHUNK-1:0] sl;
  logic             msb_cin;
  assign st[0] = '{v: bus.in_valid, s: bus.sub, c: bus.sub, a: bus.a, b: bus.b, sum: '0};
  // operands travel whole; each stage only consumes its own slice, which gives the skew
  if (STAGES > 1) begin : g_pipe
    slot_t r [STAGES-1];
    always_ff @(posedge clk)
      for (int i = 0; i < STAGES - 1; i++)
        if (reset) r[i] <= '0;
        else if (!bus.stall) r[i] <= '{v: st[i].v, s: st[i].s, c: nc[i], a: st[i].a, b: st[i].b, sum: ns[i]};
    for (genvar g = 1; g < STAGES; g++) begin : g_link
      assign st[g] = r[g-1];
    end
  end
  always_comb begin
    bx = '0;
    sl = '0;
    ns = '{default: '0};
    nc = '{default: 1'b0};
    for (int k = 0; k < STAGES; k++) begin
      bx = st[k].s ? ~st[k].b : st[k].b;
      {nc[k], sl} = {1'b0, st[k].a[k*CHUNK +: CHUNK]} + {1'b0, bx[k*CHUNK +: CHUNK]} + (CHUNK+1)'(st[k].c);
      ns[k] = st[k].sum | (WIDTH'(sl) << (k * CHUNK));
    end
  end
  // carry into the MSB recovered from the MSB sum bit and its operands
  assign msb_cin = st[L].a[WIDTH-1] ^ st[L].b[WIDTH-1] ^ st[L].s ^ ns[L][WIDTH-1];
  always_ff @(posedge clk)
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid <= st[L].v;
      if (st[L].v) begin
        bus.result    <= ns[L];
        bus.negative  <= ns[L][WIDTH-1];
        bus.zero      <= ns[L] == '0;
        bus.carry_out <= nc[L];
        bus.overflow  <= nc[L] ^ msb_cin;
      end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench driving 64/16, 8/8 and 32/4 instances in lockstep
module tb_pipelined_addsub;
  typedef struct {
    logic [67:0] val;
    int          at;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int adv = 0;
  logic held = 1'b0;
  exp_t q [3][$];
  int wd [3] = '{64, 8, 32};
  int lat [3] = '{4, 1, 8};
  logic        ov [3];
  logic [67:0] val [3];
  logic        pov [3];
  logic [67:0] pval [3];
  pipelined_addsub_if #(64) i64 ();
  pipelined_addsub_if #(8)  i8 ();
  pipelined_addsub_if #(32) i32 ();
  pipelined_addsub #(.WIDTH(64), .CHUNK(16)) u64 (.clk(clk), .reset(reset), .bus(i64.slave));
  pipelined_addsub #(.WIDTH(8),  .CHUNK(8))  u8  (.clk(clk), .reset(reset), .bus(i8.slave));
  pipelined_addsub #(.WIDTH(32), .CHUNK(4))  u32 (.clk(clk), .reset(reset), .bus(i32.slave));
  always #5 clk = ~clk;
  assign ov[0] = i64.out_valid;
  assign ov[1] = i8.out_valid;
  assign ov[2] = i32.out_valid;
  assign val[0] = {i64.negative, i64.zero, i64.carry_out, i64.overflow, i64.result};
  assign val[1] = {i8.negative, i8.zero, i8.carry_out, i8.overflow, 56'b0, i8.result};
  assign val[2] = {i32.negative, i32.zero, i32.carry_out, i32.overflow, 32'b0, i32.result};
  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [67:0] model(int w, logic s, logic [63:0] x, logic [63:0] y);
    logic [64:0] m, xb, yb, full;
    logic [63:0] r;
    logic n, c, v;
    m = (65'd1 << w) - 65'd1;
    xb = {1'b0, x} & m;
    yb = (s ? ~{1'b0, y} : {1'b0, y}) & m;
    full = xb + yb + 65'(s);
    r = full[63:0] & m[63:0];
    c = full[w];
    n = r[w-1];
    v = (xb[w-1] == yb[w-1]) && (n != xb[w-1]);
    return {n, r == 64'd0, c, v, r};
  endfunction
  task automatic drive(logic v, logic s, logic [63:0] x, logic [63:0] y, logic st);
    @(posedge clk);
    #1;
    i64.in_valid = v; i8.in_valid = v; i32.in_valid = v;
    i64.sub = s; i8.sub = s; i32.sub = s;
    i64.a = x; i8.a = x[7:0]; i32.a = x[31:0];
    i64.b = y; i8.b = y[7:0]; i32.b = y[31:0];
    i64.stall = st; i8.stall = st; i32.stall = st;
    if (v && !st)
      for (int j = 0; j < 3; j++) q[j].push_back('{model(wd[j], s, x, y), adv + lat[j]});
  endtask
  always @(posedge clk) begin
    held <= (i64.stall === 1'b1) && !reset;
    if (!reset && i64.stall !== 1'b1) adv <= adv + 1;
  end
  always @(negedge clk)
    if (!reset)
      for (int j = 0; j < 3; j++) begin
        if (held) check($sformatf("hold_w%0d", wd[j]), {ov[j], val[j]}, {pov[j], pval[j]});
        else if (ov[j]) begin
          if (q[j].size() == 0) check($sformatf("spurious_w%0d", wd[j]), ov[j], 1'b0);
          else begin
            exp_t e;
            e = q[j].pop_front();
            check($sformatf("nzcv_res_w%0d", wd[j]), val[j], e.val);
            check($sformatf("latency_w%0d", wd[j]), adv, e.at);
          end
        end
        pov[j] = ov[j];
        pval[j] = val[j];
      end
  task automatic check_zero(string tag);
    @(negedge clk);
    for (int j = 0; j < 3; j++) check($sformatf("%s_w%0d", tag, wd[j]), {ov[j], val[j]}, '0);
  endtask
  task automatic drain();
    for (int k = 0; k < 60 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) @(posedge clk);
    for (int j = 0; j < 3; j++) check($sformatf("drain_w%0d", wd[j]), q[j].size(), 0);
  endtask
  logic [63:0] da [11];
  logic [63:0] db [11];
  logic        ds [11];
  initial begin
    da = '{64'd1, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'd5, 64'd0, 64'h7F, 64'h7FFF_FFFF, 64'h80, 64'hFF};
    db = '{64'd1, 64'd1, 64'd1, 64'd1, 64'd1, 64'd5, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1};
    ds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    reset = 1'b0;
    check_zero("reset_state");
    for (int n = 0; n < 11; n++) drive(1'b1, ds[n], da[n], db[n], 1'b0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    drain();
    for (int n = 0; n < 8; n++) begin
      if (n == 3) drive(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      if (n == 5)
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      drive(1'b1, n[0], {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    drain();
    for (int n = 0; n < 3; n++) drive(1'b1, n[0], {$urandom, $urandom}, 64'd3, 1'b0);
    i64.in_valid = 1'b0; i8.in_valid = 1'b0; i32.in_valid = 1'b0;
    i64.stall = 1'b1; i8.stall = 1'b1; i32.stall = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int j = 0; j < 3; j++) q[j].delete();
    i64.stall = 1'b0; i8.stall = 1'b0; i32.stall = 1'b0;
    check_zero("reset_flush");
    repeat (10) @(posedge clk);
    drive(1'b1, 1'b0, 64'd1, 64'd1, 1'b0);
    drive(1'b1, 1'b1, 64'd0, 64'd1, 1'b0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor for the ALU datapath. It computes A+B or A−B on WIDTH-bit operands, with the carry chain split into CHUNK-bit ripple slices and one register stage per slice. It produces the ARM condition flags (N, Z, C, V) alongside the result. It replaces a single-cycle ripple chain of full adder/subtractor cells when operand width makes that chain the critical path. It accepts one operation per cycle, with a stall input and valid tagging.

## Interface
- WIDTH, 64: operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 16: bits added per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands and op on this cycle form an operation.
- sub, input, 1: 0 = A+B, 1 = A−B (computed as A + ~B + 1).
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- stall, input, 1: freezes the whole pipeline, including inputs, for this cycle.
- out_valid, output, 1: result/flags belong to a completed operation.
- result, output, WIDTH: sum or difference, modulo 2^WIDTH.
- negative, output, 1: N flag = result[WIDTH-1].
- zero, output, 1: Z flag = (result == 0).
- carry_out, output, 1: C flag = carry out of bit WIDTH-1. For subtract, 1 means no borrow (ARM convention).
- overflow, output, 1: V flag = carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..STAGES-1) adds bits [k·CHUNK +: CHUNK] of A and B', plus the registered carry from stage k−1. B' = sub ? ~b : b.
- Stage 0 carry-in is sub.
- Skew: stage k consumes operand slices delayed k cycles, so each slice meets its carry.
- Deskew: slice sums are delayed so that all WIDTH bits of one operation emerge together.
- Each stage carries a valid bit and its sub bit down the pipe with the data.
- The final stage captures carry-in and carry-out of the MSB for V and C.
- N and Z are computed from the assembled result in the output register stage.
- result and flags update only when a valid operation exits the pipe. When an exiting slot is invalid, out_valid is 0 and result and flags hold their last value.
- stall = 1: no register in the block changes. A/B/sub/in_valid presented that cycle are ignored, and the source must re-present them. out_valid, result and flags hold.
- in_valid = 0 with stall = 0 inserts a bubble. Bubbles propagate and produce out_valid = 0 at the exit cycle.

## Timing
- Latency: an operation accepted at edge t (in_valid = 1, stall = 0) appears with out_valid = 1 after edge t+STAGES, counting only non-stalled edges. Flags are valid in the same cycle as result.
- Throughput: one operation per non-stalled cycle; no back-to-back restrictions.
- Add/sub ops may be freely interleaved; each op keeps its own sub bit.
- Reset (edge with reset = 1):
  - all valid bits cleared; in-flight operations discarded.
  - out_valid, result, negative, zero, carry_out, overflow all set to 0.
  - reset has priority over stall.
  - the first operation accepted on the edge after reset deasserts exits STAGES edges later.
- STAGES = 1: a purely registered single-stage adder with latency 1; no skew registers.
- Wrap-around: the result is modulo 2^WIDTH; the carry/borrow is reported only through carry_out.

## Test plan
- WIDTH=64, CHUNK=16, add 1+1 with stall = 0 → result 0x2 and NZCV = 0000, with out_valid = 1 exactly 4 edges after acceptance.
- Add 0x0000_0000_0000_FFFF + 1 → 0x0000_0000_0001_0000, C = 0. Add 0xFFFF_FFFF_FFFF_FFFF + 1 → 0, Z = 1, C = 1, V = 0. These check the inter-stage carry and the full chain.
- Add 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000 with N = 1, V = 1, C = 0. Subtract 0x8000_0000_0000_0000 − 1 → 0x7FFF_FFFF_FFFF_FFFF with V = 1, C = 1.
- Subtract 5−5 → 0 with Z = 1, C = 1. Subtract 0−1 → 0xFFFF_FFFF_FFFF_FFFF with N = 1, C = 0, V = 0.
- Stream 8 alternating add/sub ops back-to-back with one bubble and a 3-cycle stall mid-stream. Required: results in order, the bubble appears as a single out_valid = 0 cycle, and outputs are frozen during the stall with no op lost or duplicated. Compare against a behavioural model.
- Assert reset while 3 ops are in flight → all outputs 0 on the next cycle and no out_valid = 1 for the discarded ops. Repeat the add tests at WIDTH=8, CHUNK=8 (latency 1) and WIDTH=32, CHUNK=4 (latency 8).
